// File: rtl/ex_mem_lsu.sv
// rtl/ex_mem_lsu.sv - EX/MEM pipeline register with load/store unit, alignment check and timeout
module ex_mem_lsu #(
  parameter int DATA_WIDTH          = 32,
  parameter int REGISTER_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT         = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_EX_MEM,
  input  logic [31:0]                    INST_EX,
  input  logic                           reg_write_EX,
  input  logic                           mem_write_EX,
  input  logic [1:0]                     result_sel_EX,
  input  logic [DATA_WIDTH-1:0]          alu_res_EX,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX,
  input  logic [DATA_WIDTH-1:0]          write_data_EX,
  input  logic [DATA_WIDTH-1:0]          PC_plus_4_EX,
  output logic                           dmem_req,
  output logic                           dmem_we,
  output logic [DATA_WIDTH-1:0]          dmem_addr,
  output logic [3:0]                     dmem_be,
  output logic [DATA_WIDTH-1:0]          dmem_wdata,
  input  logic                           dmem_ready,
  input  logic [DATA_WIDTH-1:0]          dmem_rdata,
  output logic                           mem_stall,
  output logic [DATA_WIDTH-1:0]          alu_res_EX_MEM_o,
  output logic [REGISTER_ADDR_WIDTH-1:0] rd_EX_MEM_o,
  output logic                           reg_write_EX_MEM_o,
  output logic [1:0]                     result_sel_EX_MEM_o,
  output logic [DATA_WIDTH-1:0]          PC_plus_4_EX_MEM_o,
  output logic [DATA_WIDTH-1:0]          load_data_MEM,
  output logic                           mem_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               wait_cnt_q, wait_cnt_d;

  logic [DATA_WIDTH-1:0]          alu_res_q;
  logic [DATA_WIDTH-1:0]          write_data_q;
  logic [DATA_WIDTH-1:0]          pc_plus_4_q;
  logic [REGISTER_ADDR_WIDTH-1:0] rd_q;
  logic                           reg_write_q;
  logic                           mem_write_q;
  logic [1:0]                     result_sel_q;
  logic [2:0]                     funct3_q;
  logic                           mem_err_q;

  logic                           is_mem_ex;
  logic                           misaligned_ex;
  logic                           go_access;
  logic                           in_access;
  logic                           timeout;
  logic [1:0]                     offset;
  logic [3:0]                     be_raw;
  logic [DATA_WIDTH-1:0]          wdata_raw;
  logic [DATA_WIDTH-1:0]          lane;
  logic [DATA_WIDTH-1:0]          load_ext;

  // A real memory op is one that is not flushed and is either a store or a load
  assign is_mem_ex = !flush_EX_MEM && (mem_write_EX || (result_sel_EX == 2'b01));
  assign go_access = is_mem_ex && !misaligned_ex;
  assign in_access = (state_q == ACCESS);
  assign mem_stall = in_access && !dmem_ready;
  assign timeout   = in_access && !dmem_ready && (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // Alignment of the incoming EX op by access size (funct3[1:0])
  always_comb begin
    misaligned_ex = 1'b0;
    case (INST_EX[13:12])
      2'b00:   misaligned_ex = 1'b0;
      2'b01:   misaligned_ex = is_mem_ex && alu_res_EX[0];
      default: misaligned_ex = is_mem_ex && (alu_res_EX[1:0] != 2'b00);
    endcase
  end

  // EX/MEM pipeline register; held while stalled, errors clear the write-back enable
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_res_q    <= '0;
      write_data_q <= '0;
      pc_plus_4_q  <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_sel_q <= 2'b00;
      funct3_q     <= 3'b000;
      mem_err_q    <= 1'b0;
    end else begin
      mem_err_q <= 1'b0;
      if (!mem_stall) begin
        alu_res_q    <= alu_res_EX;
        write_data_q <= write_data_EX;
        pc_plus_4_q  <= PC_plus_4_EX;
        rd_q         <= rd_EX;
        funct3_q     <= INST_EX[14:12];
        if (flush_EX_MEM) begin
          reg_write_q  <= 1'b0;
          mem_write_q  <= 1'b0;
          result_sel_q <= 2'b00;
        end else begin
          reg_write_q  <= reg_write_EX && !misaligned_ex;
          mem_write_q  <= mem_write_EX;
          result_sel_q <= result_sel_EX;
        end
        if (misaligned_ex) begin
          mem_err_q <= 1'b1;
        end
      end else if (timeout) begin
        reg_write_q <= 1'b0;
        mem_err_q   <= 1'b1;
      end
    end
  end

  // FSM state and wait counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state: enter ACCESS on capture of an aligned op, leave on ready or timeout
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (go_access) begin
          state_d    = ACCESS;
          wait_cnt_d = '0;
        end
      end
      ACCESS: begin
        if (dmem_ready) begin
          state_d    = go_access ? ACCESS : IDLE;
          wait_cnt_d = '0;
        end else if (timeout) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  assign offset = alu_res_q[1:0];

  // Byte enables and lane-replicated store data by access size
  always_comb begin
    be_raw    = 4'b1111;
    wdata_raw = write_data_q;
    case (funct3_q[1:0])
      2'b00: begin
        be_raw    = 4'b0001 << offset;
        wdata_raw = {4{write_data_q[7:0]}};
      end
      2'b01: begin
        be_raw    = 4'b0011 << offset;
        wdata_raw = {2{write_data_q[15:0]}};
      end
      default: begin
        be_raw    = 4'b1111;
        wdata_raw = write_data_q;
      end
    endcase
  end

  // Memory port is driven only while a request is outstanding
  always_comb begin
    dmem_req   = in_access;
    dmem_we    = in_access && mem_write_q;
    dmem_addr  = in_access ? {alu_res_q[DATA_WIDTH-1:2], 2'b00} : '0;
    dmem_be    = in_access ? be_raw : 4'b0000;
    dmem_wdata = in_access ? wdata_raw : '0;
  end

  assign lane = dmem_rdata >> {offset, 3'b000};

  // Load extension of the addressed lane; only presented in the completion cycle
  always_comb begin
    load_ext = dmem_rdata;
    case (funct3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      default: load_ext = dmem_rdata;
    endcase
    load_data_MEM = (in_access && dmem_ready && (result_sel_q == 2'b01)) ? load_ext : '0;
  end

  assign alu_res_EX_MEM_o    = alu_res_q;
  assign rd_EX_MEM_o         = rd_q;
  assign reg_write_EX_MEM_o  = reg_write_q;
  assign result_sel_EX_MEM_o = result_sel_q;
  assign PC_plus_4_EX_MEM_o  = pc_plus_4_q;
  assign mem_err             = mem_err_q;

endmodule

// File: tb/tb_ex_mem_lsu.sv
// tb/tb_ex_mem_lsu.sv - self-checking bench for ex_mem_lsu
module tb_ex_mem_lsu;

  logic        clk;
  logic        rst;
  logic        flush_EX_MEM;
  logic [31:0] INST_EX;
  logic        reg_write_EX;
  logic        mem_write_EX;
  logic [1:0]  result_sel_EX;
  logic [31:0] alu_res_EX;
  logic [4:0]  rd_EX;
  logic [31:0] write_data_EX;
  logic [31:0] PC_plus_4_EX;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] alu_res_EX_MEM_o;
  logic [4:0]  rd_EX_MEM_o;
  logic        reg_write_EX_MEM_o;
  logic [1:0]  result_sel_EX_MEM_o;
  logic [31:0] PC_plus_4_EX_MEM_o;
  logic [31:0] load_data_MEM;
  logic        mem_err;

  ex_mem_lsu #(
    .DATA_WIDTH(32),
    .REGISTER_ADDR_WIDTH(5),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush_EX_MEM(flush_EX_MEM),
    .INST_EX(INST_EX),
    .reg_write_EX(reg_write_EX),
    .mem_write_EX(mem_write_EX),
    .result_sel_EX(result_sel_EX),
    .alu_res_EX(alu_res_EX),
    .rd_EX(rd_EX),
    .write_data_EX(write_data_EX),
    .PC_plus_4_EX(PC_plus_4_EX),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall),
    .alu_res_EX_MEM_o(alu_res_EX_MEM_o),
    .rd_EX_MEM_o(rd_EX_MEM_o),
    .reg_write_EX_MEM_o(reg_write_EX_MEM_o),
    .result_sel_EX_MEM_o(result_sel_EX_MEM_o),
    .PC_plus_4_EX_MEM_o(PC_plus_4_EX_MEM_o),
    .load_data_MEM(load_data_MEM),
    .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  funct3;
    logic        is_load;
    logic        is_store;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          wait_n;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ld;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic        is_load;
    logic [31:0] ld;
  } exp_t;

  vec_t vecs[14];
  exp_t sb_q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bubble();
    flush_EX_MEM  = 1'b0;
    INST_EX       = 32'h0;
    reg_write_EX  = 1'b0;
    mem_write_EX  = 1'b0;
    result_sel_EX = 2'b00;
    alu_res_EX    = 32'h0;
    rd_EX         = 5'd0;
    write_data_EX = 32'h0;
    PC_plus_4_EX  = 32'h0;
  endtask

  task automatic drive_ex(input logic [2:0] f3, input logic ld, input logic st,
                          input logic [31:0] addr, input logic [31:0] wd);
    flush_EX_MEM  = 1'b0;
    INST_EX       = {17'h0, f3, 12'h003};
    reg_write_EX  = ld;
    mem_write_EX  = st;
    result_sel_EX = ld ? 2'b01 : 2'b00;
    alu_res_EX    = addr;
    rd_EX         = 5'd5;
    write_data_EX = wd;
    PC_plus_4_EX  = 32'h1004;
  endtask

  initial begin
    vec_t v;
    exp_t e;
    int   stalls;
    bit   done;
    bit   req_bad;

    //          funct3  ld    st    addr        wd            rdata         w  be    wdata         ld_exp        mis
    vecs[0]  = '{3'b010, 1'b1, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[1]  = '{3'b000, 1'b1, 1'b0, 32'h103, 32'h0,        32'h80123456, 3, 4'h8, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[2]  = '{3'b100, 1'b1, 1'b0, 32'h103, 32'h0,        32'h80123456, 3, 4'h8, 32'h0,        32'h00000080, 1'b0};
    vecs[3]  = '{3'b001, 1'b0, 1'b1, 32'h202, 32'h1234ABCD, 32'h0,        0, 4'hC, 32'hABCDABCD, 32'h0,        1'b0};
    vecs[4]  = '{3'b010, 1'b1, 1'b0, 32'h101, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        1'b1};
    vecs[5]  = '{3'b001, 1'b1, 1'b0, 32'h102, 32'h0,        32'hF00D1234, 1, 4'hC, 32'h0,        32'hFFFFF00D, 1'b0};
    vecs[6]  = '{3'b101, 1'b1, 1'b0, 32'h102, 32'h0,        32'hF00D1234, 2, 4'hC, 32'h0,        32'h0000F00D, 1'b0};
    vecs[7]  = '{3'b000, 1'b0, 1'b1, 32'h041, 32'h000000A5, 32'h0,        1, 4'h2, 32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[8]  = '{3'b010, 1'b0, 1'b1, 32'h300, 32'hCAFEF00D, 32'h0,        0, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[9]  = '{3'b001, 1'b1, 1'b0, 32'h201, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{3'b001, 1'b0, 1'b1, 32'h203, 32'h55667788, 32'h0,        0, 4'h0, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{3'b000, 1'b1, 1'b0, 32'h000, 32'h0,        32'h0000007F, 0, 4'h1, 32'h0,        32'h0000007F, 1'b0};
    vecs[12] = '{3'b101, 1'b1, 1'b0, 32'h100, 32'h0,        32'h12348765, 2, 4'h3, 32'h0,        32'h00008765, 1'b0};
    vecs[13] = '{3'b000, 1'b1, 1'b0, 32'h101, 32'h0,        32'h8012B456, 0, 4'h2, 32'h0,        32'hFFFFFFB4, 1'b0};

    rst        = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    bubble();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    chk("rst_regwr", 32'(reg_write_EX_MEM_o), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven single operations
    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      drive_ex(v.funct3, v.is_load, v.is_store, v.addr, v.wd);
      @(posedge clk); #1;
      bubble();
      if (v.exp_mis) begin
        @(negedge clk);
        chk($sformatf("v%0d_mis_req", i), 32'(dmem_req), 32'h0);
        chk($sformatf("v%0d_mis_err", i), 32'(mem_err), 32'h1);
        chk($sformatf("v%0d_mis_regwr", i), 32'(reg_write_EX_MEM_o), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("v%0d_mis_err_clr", i), 32'(mem_err), 32'h0);
        @(posedge clk); #1;
      end else begin
        e.is_load = v.is_load;
        e.ld      = v.exp_ld;
        sb_q.push_back(e);
        done    = 1'b0;
        stalls  = 0;
        req_bad = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
          dmem_ready = (c == v.wait_n);
          dmem_rdata = dmem_ready ? v.rdata : $urandom;
          @(negedge clk);
          if (c == 0) begin
            chk($sformatf("v%0d_addr", i), dmem_addr, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d_be", i), 32'(dmem_be), 32'(v.exp_be));
            chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(v.is_store));
            chk($sformatf("v%0d_alu_o", i), alu_res_EX_MEM_o, v.addr);
            chk($sformatf("v%0d_regwr", i), 32'(reg_write_EX_MEM_o), 32'(v.is_load));
            if (v.is_store) chk($sformatf("v%0d_wdata", i), dmem_wdata, v.exp_wdata);
          end
          if (!dmem_req || dmem_be !== v.exp_be || dmem_we !== v.is_store) req_bad = 1'b1;
          if (mem_stall) stalls++;
          if (dmem_ready) begin
            e = sb_q.pop_front();
            if (e.is_load) chk($sformatf("v%0d_load", i), load_data_MEM, e.ld);
            done = 1'b1;
          end
          @(posedge clk); #1;
        end
        dmem_ready = 1'b0;
        chk($sformatf("v%0d_done", i), 32'(done), 32'h1);
        chk($sformatf("v%0d_stalls", i), 32'(stalls), 32'(v.wait_n));
        chk($sformatf("v%0d_req_stable", i), 32'(req_bad), 32'h0);
        @(negedge clk);
        chk($sformatf("v%0d_idle_req", i), 32'(dmem_req), 32'h0);
        @(posedge clk); #1;
      end
    end

    // Flushed load becomes a bubble
    drive_ex(3'b010, 1'b1, 1'b0, 32'h600, 32'h0);
    flush_EX_MEM = 1'b1;
    @(posedge clk); #1;
    bubble();
    @(negedge clk);
    chk("flush_req", 32'(dmem_req), 32'h0);
    chk("flush_regwr", 32'(reg_write_EX_MEM_o), 32'h0);
    chk("flush_rsel", 32'(result_sel_EX_MEM_o), 32'h0);
    chk("flush_err", 32'(mem_err), 32'h0);
    @(posedge clk); #1;

    // Back-to-back zero-wait loads keep ACCESS without a gap
    drive_ex(3'b010, 1'b1, 1'b0, 32'h700, 32'h0);
    @(posedge clk); #1;
    drive_ex(3'b010, 1'b1, 1'b0, 32'h704, 32'h0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hAAAA5555;
    @(negedge clk);
    chk("b2b_req0", 32'(dmem_req), 32'h1);
    chk("b2b_addr0", dmem_addr, 32'h700);
    chk("b2b_ld0", load_data_MEM, 32'hAAAA5555);
    chk("b2b_stall0", 32'(mem_stall), 32'h0);
    @(posedge clk); #1;
    bubble();
    dmem_rdata = 32'h12345678;
    @(negedge clk);
    chk("b2b_req1", 32'(dmem_req), 32'h1);
    chk("b2b_addr1", dmem_addr, 32'h704);
    chk("b2b_ld1", load_data_MEM, 32'h12345678);
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    @(negedge clk);
    chk("b2b_idle", 32'(dmem_req), 32'h0);
    @(posedge clk); #1;

    // Timeout with ready held low; EX/MEM must hold and ignore flush while stalled
    drive_ex(3'b010, 1'b1, 1'b0, 32'h400, 32'h0);
    @(posedge clk); #1;
    drive_ex(3'b010, 1'b1, 1'b0, 32'h999, 32'h0);
    flush_EX_MEM = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("to_req%0d", c), 32'(dmem_req), 32'h1);
      chk($sformatf("to_stall%0d", c), 32'(mem_stall), 32'h1);
      chk($sformatf("to_hold%0d", c), alu_res_EX_MEM_o, 32'h400);
      chk($sformatf("to_regwr%0d", c), 32'(reg_write_EX_MEM_o), 32'h1);
      @(posedge clk); #1;
    end
    bubble();
    @(negedge clk);
    chk("to_abort_req", 32'(dmem_req), 32'h0);
    chk("to_abort_err", 32'(mem_err), 32'h1);
    chk("to_abort_stall", 32'(mem_stall), 32'h0);
    chk("to_abort_regwr", 32'(reg_write_EX_MEM_o), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_err_clr", 32'(mem_err), 32'h0);
    @(posedge clk); #1;

    // Reset asserted in the middle of an outstanding store
    drive_ex(3'b010, 1'b0, 1'b1, 32'h500, 32'h11223344);
    @(posedge clk); #1;
    bubble();
    @(negedge clk);
    chk("rm_req_before", 32'(dmem_req), 32'h1);
    @(posedge clk); #1;
    rst        = 1'b1;
    dmem_ready = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rm_req", 32'(dmem_req), 32'h0);
    chk("rm_we", 32'(dmem_we), 32'h0);
    chk("rm_be", 32'(dmem_be), 32'h0);
    chk("rm_addr", dmem_addr, 32'h0);
    chk("rm_wdata", dmem_wdata, 32'h0);
    chk("rm_stall", 32'(mem_stall), 32'h0);
    chk("rm_err", 32'(mem_err), 32'h0);
    chk("rm_alu", alu_res_EX_MEM_o, 32'h0);
    chk("rm_rd", 32'(rd_EX_MEM_o), 32'h0);
    chk("rm_regwr", 32'(reg_write_EX_MEM_o), 32'h0);
    chk("rm_rsel", 32'(result_sel_EX_MEM_o), 32'h0);
    chk("rm_pc4", PC_plus_4_EX_MEM_o, 32'h0);
    chk("rm_load", load_data_MEM, 32'h0);
    rst        = 1'b0;
    dmem_ready = 1'b0;
    @(posedge clk); #1;

    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
